matrix_mul_seq: RTL and testbench

//  Parametrised sequential NxN matrix multiplier, successor to the combinational 2x2 matrixMul.

---
 rtl/matrix_mul_pkg.sv | 25 ++
 rtl/matrix_mul_seq_if.sv | 25 ++
 rtl/matrix_mul_seq_mac_unit.sv | 44 ++++
 rtl/matrix_mul_seq.sv | 148 ++++++++++++++
 tb/tb_matrix_mul_seq.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_mul_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
// Covers the FSM state encoding, packed-element indexing and accumulator sizing.
package matrix_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (i,j); row 0, col 0 occupies the MSBs of the packed vector.
    function automatic int elem_lsb(input int i, input int j, input int n, input int ew);
        return (n * n - 1 - (i * n + j)) * ew;
    endfunction

    // An N-term dot product of W-bit operands fits in 2*W+clog2(N) bits; keep at least one guard bit.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + ((n > 1) ? $clog2(n) : 1);
    endfunction

    localparam int DEFAULT_N     = 2;
    localparam int DEFAULT_W     = 8;
    localparam int DEFAULT_ACC_W = acc_width(DEFAULT_W, DEFAULT_N);

endpackage

// File: rtl/matrix_mul_seq_if.sv
// Operand-in / result-out handshake bundle of the sequential matrix multiplier.
// The loader-side driver uses the master modport; the multiplier uses slave.
interface matrix_mul_seq_if #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int OUT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*N*W-1:0]     A;
    logic [N*N*W-1:0]     B;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*N*OUT_W-1:0] Res;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Res
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Res
    );
endinterface

// File: rtl/matrix_mul_seq_mac_unit.sv
// Single shared multiply-accumulate: registered accumulator, combinational acc + a*b.
// The accumulator is wide enough that a full dot product never wraps internally.
module mac_unit #(
    parameter int W      = 8,
    parameter int ACC_W  = 17,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;

    // Operands are widened to the accumulator width first so the low ACC_W bits are exact.
    if (SIGNED != 0) begin : g_signed
        logic signed [ACC_W-1:0] a_ext;
        logic signed [ACC_W-1:0] b_ext;
        assign a_ext = ACC_W'($signed(a));
        assign b_ext = ACC_W'($signed(b));
        assign prod  = a_ext * b_ext;
    end else begin : g_unsigned
        assign prod = ACC_W'(a) * ACC_W'(b);
    end

    assign sum = acc + prod;

    // clr wins over en so the last term of a dot product can be consumed and cleared together.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential NxN matrix multiplier: latches A/B on a handshake, walks i/j/k through one
// shared MAC (N^3 cycles), then presents Res until the consumer accepts it.
module matrix_mul_seq
    import matrix_mul_pkg::*;
#(
    parameter int N      = 2,
    parameter int W      = 8,
    parameter int OUT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    matrix_mul_seq_if.slave bus
);

    localparam int ACC_W = acc_width(W, N);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]     i;
    logic [IDX_W-1:0]     j;
    logic [IDX_W-1:0]     k;
    logic [N*N*W-1:0]     a_reg;
    logic [N*N*W-1:0]     b_reg;
    logic [N*N*OUT_W-1:0] res_reg;

    logic             load;
    logic             mac_clr;
    logic             mac_en;
    logic             in_ready;
    logic             out_valid;
    logic             last_k;
    logic             last_step;
    logic [W-1:0]     a_elem;
    logic [W-1:0]     b_elem;
    logic [ACC_W-1:0] mac_sum;
    logic [OUT_W-1:0] res_elem;

    assign a_elem    = a_reg[elem_lsb(int'(i), int'(k), N, W) +: W];
    assign b_elem    = b_reg[elem_lsb(int'(k), int'(j), N, W) +: W];
    assign last_k    = (k == LAST);
    assign last_step = last_k && (i == LAST) && (j == LAST);

    // Narrower results keep the low bits; wider results are sign- or zero-extended.
    if (OUT_W <= ACC_W) begin : g_trunc
        assign res_elem = mac_sum[OUT_W-1:0];
    end else if (SIGNED != 0) begin : g_sext
        assign res_elem = OUT_W'($signed(mac_sum));
    end else begin : g_zext
        assign res_elem = OUT_W'(mac_sum);
    end

    mac_unit #(
        .W      (W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (a_elem),
        .b   (b_elem),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    mac_clr    = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = last_k;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are captured only at accept; each finished dot product lands in Res(i,j).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
        end else if (load) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else if (state == MAC) begin
            if (last_k) begin
                res_reg[elem_lsb(int'(i), int'(j), N, OUT_W) +: OUT_W] <= res_elem;
                k <= '0;
                if (j == LAST) begin
                    j <= '0;
                    i <= (i == LAST) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Res       = res_reg;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Self-checking bench for matrix_mul_seq: several parameterisations driven through one
// selectable stimulus path and compared against a plain-arithmetic matrix product.
module tb_matrix_mul_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [511:0] drv_a;
    logic [511:0] drv_b;
    int           sel;
    int           cur_n;
    int           cur_w;
    int           cur_ow;
    int           cur_sg;
    int           n_pass;
    int           n_checks;

    logic         obs_in_ready;
    logic         obs_out_valid;
    logic [511:0] obs_res;

    always #5 clk = ~clk;

    matrix_mul_seq_if #(.N(2), .W(8), .OUT_W(8))  bus0 ();
    matrix_mul_seq_if #(.N(3), .W(8), .OUT_W(8))  bus1 ();
    matrix_mul_seq_if #(.N(2), .W(8), .OUT_W(18)) bus2 ();
    matrix_mul_seq_if #(.N(2), .W(8), .OUT_W(16)) bus3 ();
    matrix_mul_seq_if #(.N(1), .W(8), .OUT_W(8))  bus4 ();

    assign bus0.in_valid  = in_valid && (sel == 0);
    assign bus0.out_ready = out_ready && (sel == 0);
    assign bus0.A         = drv_a[31:0];
    assign bus0.B         = drv_b[31:0];
    assign bus1.in_valid  = in_valid && (sel == 1);
    assign bus1.out_ready = out_ready && (sel == 1);
    assign bus1.A         = drv_a[71:0];
    assign bus1.B         = drv_b[71:0];
    assign bus2.in_valid  = in_valid && (sel == 2);
    assign bus2.out_ready = out_ready && (sel == 2);
    assign bus2.A         = drv_a[31:0];
    assign bus2.B         = drv_b[31:0];
    assign bus3.in_valid  = in_valid && (sel == 3);
    assign bus3.out_ready = out_ready && (sel == 3);
    assign bus3.A         = drv_a[31:0];
    assign bus3.B         = drv_b[31:0];
    assign bus4.in_valid  = in_valid && (sel == 4);
    assign bus4.out_ready = out_ready && (sel == 4);
    assign bus4.A         = drv_a[7:0];
    assign bus4.B         = drv_b[7:0];

    matrix_mul_seq #(.N(2), .W(8), .OUT_W(8),  .SIGNED(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    matrix_mul_seq #(.N(3), .W(8), .OUT_W(8),  .SIGNED(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    matrix_mul_seq #(.N(2), .W(8), .OUT_W(18), .SIGNED(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    matrix_mul_seq #(.N(2), .W(8), .OUT_W(16), .SIGNED(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    matrix_mul_seq #(.N(1), .W(8), .OUT_W(8),  .SIGNED(0)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always_comb begin
        obs_in_ready  = 1'b0;
        obs_out_valid = 1'b0;
        obs_res       = '0;
        case (sel)
            0: begin obs_in_ready = bus0.in_ready; obs_out_valid = bus0.out_valid; obs_res = 512'(bus0.Res); end
            1: begin obs_in_ready = bus1.in_ready; obs_out_valid = bus1.out_valid; obs_res = 512'(bus1.Res); end
            2: begin obs_in_ready = bus2.in_ready; obs_out_valid = bus2.out_valid; obs_res = 512'(bus2.Res); end
            3: begin obs_in_ready = bus3.in_ready; obs_out_valid = bus3.out_valid; obs_res = 512'(bus3.Res); end
            4: begin obs_in_ready = bus4.in_ready; obs_out_valid = bus4.out_valid; obs_res = 512'(bus4.Res); end
            default: begin end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input int s);
        int ns[5]  = '{2, 3, 2, 2, 1};
        int ows[5] = '{8, 8, 18, 16, 8};
        int sgs[5] = '{0, 0, 0, 1, 0};
        sel    = s;
        cur_n  = ns[s];
        cur_w  = 8;
        cur_ow = ows[s];
        cur_sg = sgs[s];
    endtask

    function automatic logic [511:0] pack_mat(input int e[9], input int n, input int ew);
        logic [511:0] v = '0;
        for (int idx = 0; idx < n * n; idx++) begin
            for (int b = 0; b < ew; b++) begin
                v[(n * n - 1 - idx) * ew + b] = e[idx][b];
            end
        end
        return v;
    endfunction

    // Reference: textbook row-by-column product in 64-bit integers, then keep the low ow bits.
    function automatic logic [511:0] ref_mul(input int ea[9], input int eb[9], input int n, input int ow);
        logic [511:0] r = '0;
        longint       acc;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                acc = 0;
                for (int k = 0; k < n; k++) begin
                    acc += longint'(ea[i * n + k]) * longint'(eb[k * n + j]);
                end
                for (int b = 0; b < ow; b++) begin
                    r[(n * n - 1 - (i * n + j)) * ow + b] = acc[b];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [511:0] rand_wide();
        logic [511:0] v;
        for (int q = 0; q < 16; q++) begin
            v[q * 32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic gen_mat(output int e[9]);
        for (int idx = 0; idx < 9; idx++) begin
            e[idx] = int'($urandom_range(0, (1 << cur_w) - 1));
            if (cur_sg != 0) begin
                e[idx] -= (1 << (cur_w - 1));
            end
        end
    endtask

    // One full transaction with latency, result, optional backpressure hold and release checks.
    task automatic applyStimulus(input int ea[9], input int eb[9], input int hold, input string tag,
                                 output logic [511:0] res_seen);
        logic [511:0] exp;
        int           cycles;
        exp = ref_mul(ea, eb, cur_n, cur_ow);
        @(negedge clk);
        drv_a     = pack_mat(ea, cur_n, cur_w);
        drv_b     = pack_mat(eb, cur_n, cur_w);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        checkOutput({tag, "_in_ready"}, 512'(obs_in_ready), 512'(1));
        @(negedge clk);
        in_valid = 1'b0;
        drv_a    = rand_wide();
        drv_b    = rand_wide();
        cycles   = 1;
        while (!obs_out_valid && cycles < 300) begin
            if (cycles == 1) begin
                checkOutput({tag, "_busy"}, 512'(obs_in_ready), 512'(0));
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 512'(cycles), 512'(cur_n * cur_n * cur_n + 1));
        checkOutput({tag, "_res"}, obs_res, exp);
        res_seen = obs_res;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            checkOutput({tag, "_hold_valid"}, 512'(obs_out_valid), 512'(1));
            checkOutput({tag, "_hold_res"}, obs_res, exp);
            checkOutput({tag, "_hold_in_ready"}, 512'(obs_in_ready), 512'(0));
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput({tag, "_drop_valid"}, 512'(obs_out_valid), 512'(0));
        checkOutput({tag, "_idle_ready"}, 512'(obs_in_ready), 512'(1));
        out_ready = 1'b0;
    endtask

    // Random in_valid/out_ready traffic; accepted operands queue their expected product.
    task automatic run_random(input int count, input int budget);
        logic [511:0] expq[$];
        logic [511:0] exp_cur;
        int           ea[9];
        int           eb[9];
        int           issued  = 0;
        int           done    = 0;
        bit           pending = 1'b0;
        exp_cur = '0;
        for (int cyc = 0; cyc < budget && done < count; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (!pending) begin
                if (issued < count && $urandom_range(0, 1) == 1) begin
                    gen_mat(ea);
                    gen_mat(eb);
                    drv_a   = pack_mat(ea, cur_n, cur_w);
                    drv_b   = pack_mat(eb, cur_n, cur_w);
                    exp_cur = ref_mul(ea, eb, cur_n, cur_ow);
                    pending = 1'b1;
                end else begin
                    drv_a = rand_wide();
                    drv_b = rand_wide();
                end
            end
            in_valid = pending;
            if (in_valid && obs_in_ready) begin
                expq.push_back(exp_cur);
                pending = 1'b0;
                issued++;
            end
            if (obs_out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checkOutput("rand_spurious", 512'(1), 512'(0));
                end else begin
                    checkOutput("rand_res", obs_res, expq.pop_front());
                end
                done++;
            end
        end
        checkOutput("rand_count", 512'(done), 512'(count));
        checkOutput("rand_queue_empty", 512'(expq.size()), 512'(0));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int           ea[9];
        int           eb[9];
        logic [511:0] seen;
        logic [71:0]  wide18;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drv_a     = '0;
        drv_b     = '0;
        n_pass    = 0;
        n_checks  = 0;
        set_cfg(0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 5; s++) begin
            set_cfg(s);
            #1;
            checkOutput("reset_in_ready", 512'(obs_in_ready), 512'(1));
            checkOutput("reset_out_valid", 512'(obs_out_valid), 512'(0));
            checkOutput("reset_res", obs_res, 512'(0));
        end

        set_cfg(0);
        ea = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        eb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        applyStimulus(ea, eb, 0, "basic", seen);
        checkOutput("basic_const", seen, 512'(32'h1316_2B32));

        set_cfg(1);
        ea = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        eb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        applyStimulus(ea, eb, 20, "ident", seen);
        checkOutput("ident_equals_b", seen, pack_mat(eb, 3, 8));

        set_cfg(0);
        ea = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
        eb = '{255, 255, 255, 255, 0, 0, 0, 0, 0};
        applyStimulus(ea, eb, 0, "trunc8", seen);
        checkOutput("trunc8_const", seen, 512'(32'h0202_0202));
        set_cfg(2);
        applyStimulus(ea, eb, 0, "trunc18", seen);
        wide18 = {18'd130050, 18'd130050, 18'd130050, 18'd130050};
        checkOutput("trunc18_const", seen, 512'(wide18));

        set_cfg(3);
        ea = '{-1, 2, 3, -4, 0, 0, 0, 0, 0};
        eb = '{5, -6, 7, 8, 0, 0, 0, 0, 0};
        applyStimulus(ea, eb, 0, "signed", seen);
        checkOutput("signed_const", seen, 512'(64'h0009_0016_FFF3_FFCE));

        // Abort a computation four cycles after accept, then run a fresh one.
        set_cfg(0);
        @(negedge clk);
        drv_a    = pack_mat('{1, 2, 3, 4, 0, 0, 0, 0, 0}, 2, 8);
        drv_b    = pack_mat('{5, 6, 7, 8, 0, 0, 0, 0, 0}, 2, 8);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready", 512'(obs_in_ready), 512'(1));
        checkOutput("midrst_out_valid", 512'(obs_out_valid), 512'(0));
        checkOutput("midrst_res", obs_res, 512'(0));
        ea = '{9, 8, 7, 6, 0, 0, 0, 0, 0};
        eb = '{2, 3, 4, 5, 0, 0, 0, 0, 0};
        applyStimulus(ea, eb, 0, "after_rst", seen);

        set_cfg(4);
        gen_mat(ea);
        gen_mat(eb);
        applyStimulus(ea, eb, 0, "n1", seen);

        set_cfg(0);
        run_random(100, 12000);
        set_cfg(3);
        run_random(40, 6000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
